// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle Moore sequencer driving every enable and mux select of the CPU datapath.
// Latency: 4-6 cycles FETCH to FETCH by instruction class; outputs decode state and instr combinationally.
// No backpressure: advances every cycle; while reset is high all enables and selects are forced to 0.
module cpu_control_fsm #(
  parameter int REG_WIDTH  = 16,
  parameter int FLAG_WIDTH = 5,
  parameter int STATE_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_WIDTH-1:0]  instr,
  input  logic [FLAG_WIDTH-1:0] flags,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  rf_we,
  output logic                  mem_we,
  output logic                  flags_we,
  output logic [1:0]            muxrf_select,
  output logic                  muxpc_select,
  output logic                  muxmem_select,
  output logic                  muxa_select,
  output logic [1:0]            muxb_select,
  output logic                  alu_op_select,
  output logic                  alu_force_add,
  output logic [STATE_BITS-1:0] state
);

  localparam logic [STATE_BITS-1:0] S_FETCH  = STATE_BITS'(0);
  localparam logic [STATE_BITS-1:0] S_IRLD   = STATE_BITS'(1);
  localparam logic [STATE_BITS-1:0] S_DECODE = STATE_BITS'(2);
  localparam logic [STATE_BITS-1:0] S_ALU    = STATE_BITS'(3);
  localparam logic [STATE_BITS-1:0] S_ALUI   = STATE_BITS'(4);
  localparam logic [STATE_BITS-1:0] S_MOV    = STATE_BITS'(5);
  localparam logic [STATE_BITS-1:0] S_MOVI   = STATE_BITS'(6);
  localparam logic [STATE_BITS-1:0] S_LOAD   = STATE_BITS'(7);
  localparam logic [STATE_BITS-1:0] S_LDWB   = STATE_BITS'(8);
  localparam logic [STATE_BITS-1:0] S_STORE  = STATE_BITS'(9);
  localparam logic [STATE_BITS-1:0] S_BRANCH = STATE_BITS'(10);
  localparam logic [STATE_BITS-1:0] S_JUMP   = STATE_BITS'(11);
  localparam logic [STATE_BITS-1:0] S_PCINC  = STATE_BITS'(12);

  localparam logic [3:0] OP_REG    = 4'h0;
  localparam logic [3:0] OP_MEMJMP = 4'h4;
  localparam logic [3:0] OP_BCOND  = 4'hC;
  localparam logic [3:0] OP_MOVI   = 4'hD;
  localparam logic [3:0] OP_LUI    = 4'hF;
  localparam logic [3:0] CODE_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STORE = 4'h4;
  localparam logic [3:0] EXT_JUMP  = 4'hC;

  logic [STATE_BITS-1:0] state_q, state_d;
  logic [3:0]            opcode, cond, ext;
  logic                  cond_true;
  logic                  f_c, f_l, f_f, f_z, f_n;
  logic                  unused_src;

  assign opcode     = instr[15:12];
  assign cond       = instr[11:8];
  assign ext        = instr[7:4];
  assign unused_src = ^instr[3:0];

  assign f_c = flags[4];
  assign f_l = flags[3];
  assign f_f = flags[2];
  assign f_z = flags[1];
  assign f_n = flags[0];

  // ALU operation codes shared by the register form (ext) and immediate form (opcode)
  function automatic logic is_alu_code(input logic [3:0] code);
    return code inside {4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3};
  endfunction

  // Branch/jump condition evaluated against the live flags register
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = f_z;
      4'h1: cond_true = !f_z;
      4'h2: cond_true = f_c;
      4'h3: cond_true = !f_c;
      4'h4: cond_true = f_l;
      4'h5: cond_true = !f_l;
      4'h6: cond_true = f_n;
      4'h7: cond_true = !f_n;
      4'h8: cond_true = f_f;
      4'h9: cond_true = !f_f;
      4'hA: cond_true = !f_l && !f_z;
      4'hB: cond_true = f_l || f_z;
      4'hC: cond_true = !f_n && !f_z;
      4'hD: cond_true = f_n || f_z;
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH and abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed fetch/decode prologue, dispatch in DECODE, all paths close through FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_IRLD;
      S_IRLD:   state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_PCINC;
        if (opcode == OP_REG) begin
          if (is_alu_code(ext))   state_d = S_ALU;
          else if (ext == EXT_MOV) state_d = S_MOV;
        end else if (is_alu_code(opcode)) begin
          state_d = S_ALUI;
        end else if (opcode == OP_MOVI || opcode == OP_LUI) begin
          state_d = S_MOVI;
        end else if (opcode == OP_MEMJMP) begin
          if (ext == EXT_LOAD)       state_d = S_LOAD;
          else if (ext == EXT_STORE) state_d = S_STORE;
          else if (ext == EXT_JUMP)  state_d = S_JUMP;
        end else if (opcode == OP_BCOND) begin
          state_d = S_BRANCH;
        end
      end
      S_ALU, S_ALUI, S_MOV, S_MOVI, S_STORE, S_LDWB: state_d = S_PCINC;
      S_LOAD:   state_d = S_LDWB;
      S_BRANCH, S_JUMP: state_d = cond_true ? S_FETCH : S_PCINC;
      S_PCINC:  state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs from state (and instr fields); everything held at 0 while reset is asserted
  always_comb begin
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    mem_we        = 1'b0;
    flags_we      = 1'b0;
    muxrf_select  = 2'd0;
    muxpc_select  = 1'b0;
    muxmem_select = 1'b0;
    muxa_select   = 1'b0;
    muxb_select   = 2'd0;
    alu_op_select = 1'b0;
    alu_force_add = 1'b0;
    state         = S_FETCH;
    if (!reset) begin
      state = state_q;
      case (state_q)
        S_FETCH:  muxmem_select = 1'b1;
        S_IRLD:   ir_we = 1'b1;
        S_ALU: begin
          flags_we = 1'b1;
          rf_we    = (ext != CODE_CMP);
        end
        S_ALUI: begin
          alu_op_select = 1'b1;
          muxb_select   = 2'd1;
          flags_we      = 1'b1;
          rf_we         = (opcode != CODE_CMP);
        end
        S_MOV: begin
          rf_we        = 1'b1;
          muxrf_select = 2'd2;
        end
        S_MOVI: begin
          rf_we        = 1'b1;
          muxrf_select = 2'd3;
        end
        S_LDWB: begin
          rf_we        = 1'b1;
          muxrf_select = 2'd1;
        end
        S_STORE:  mem_we = 1'b1;
        S_BRANCH: begin
          muxa_select   = 1'b1;
          muxb_select   = 2'd1;
          alu_force_add = 1'b1;
          pc_we         = cond_true;
        end
        S_JUMP: begin
          muxpc_select = 1'b1;
          pc_we        = cond_true;
        end
        S_PCINC: begin
          muxa_select   = 1'b1;
          muxb_select   = 2'd2;
          alu_force_add = 1'b1;
          pc_we         = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: scoreboard bench for the CPU control sequencer.
// Each instruction issued pushes its expected per-cycle output trace; a monitor pops one per cycle.
// Reference traces are built from instruction class and condition tables, not from a state machine.
module tb_cpu_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       ir_we;
    logic       pc_we;
    logic       rf_we;
    logic       mem_we;
    logic       flags_we;
    logic [1:0] muxrf;
    logic       muxpc;
    logic       muxmem;
    logic       muxa;
    logic [1:0] muxb;
    logic       alu_op;
    logic       force_add;
  } obs_t;

  typedef enum {K_ALU, K_ALUI, K_MOV, K_MOVI, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_NOP} kind_e;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [4:0]  flags;
  logic        ir_we, pc_we, rf_we, mem_we, flags_we;
  logic [1:0]  muxrf_select, muxb_select;
  logic        muxpc_select, muxmem_select, muxa_select, alu_op_select, alu_force_add;
  logic [3:0]  state;

  obs_t sb_q[$];
  obs_t exp_seq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .flags(flags),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .mem_we(mem_we), .flags_we(flags_we),
    .muxrf_select(muxrf_select), .muxpc_select(muxpc_select), .muxmem_select(muxmem_select),
    .muxa_select(muxa_select), .muxb_select(muxb_select), .alu_op_select(alu_op_select),
    .alu_force_add(alu_force_add), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit alu_code(input logic [3:0] c);
    return (c == 4'h5) || (c == 4'h9) || (c == 4'hB) || (c == 4'h1) || (c == 4'h2) || (c == 4'h3);
  endfunction

  function automatic kind_e classify(input logic [15:0] ins);
    logic [3:0] op;
    logic [3:0] ex;
    op = ins[15:12];
    ex = ins[7:4];
    if (op == 4'h0) return alu_code(ex) ? K_ALU : (ex == 4'hD ? K_MOV : K_NOP);
    if (alu_code(op)) return K_ALUI;
    if (op == 4'hD || op == 4'hF) return K_MOVI;
    if (op == 4'h4) begin
      if (ex == 4'h0) return K_LOAD;
      if (ex == 4'h4) return K_STORE;
      if (ex == 4'hC) return K_JUMP;
      return K_NOP;
    end
    if (op == 4'hC) return K_BRANCH;
    return K_NOP;
  endfunction

  // Condition table keyed by name, flags given as {C,L,F,Z,N}
  function automatic bit cond_holds(input logic [3:0] cnd, input logic [4:0] fl);
    bit c, l, f, z, n;
    {c, l, f, z, n} = fl;
    case (cnd)
      4'h0: return z;        4'h1: return !z;
      4'h2: return c;        4'h3: return !c;
      4'h4: return l;        4'h5: return !l;
      4'h6: return n;        4'h7: return !n;
      4'h8: return f;        4'h9: return !f;
      4'hA: return !l && !z; 4'hB: return l || z;
      4'hC: return !n && !z; 4'hD: return n || z;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t blank(input int st);
    obs_t o;
    o    = '0;
    o.st = 4'(st);
    return o;
  endfunction

  // Build the full cycle-by-cycle trace of one instruction into exp_seq
  function automatic void build(input logic [15:0] ins, input logic [4:0] fl);
    obs_t  o;
    kind_e k;
    bit    taken;
    k     = classify(ins);
    taken = 1'b0;
    exp_seq.delete();
    o = blank(0);  o.muxmem = 1'b1; exp_seq.push_back(o);
    o = blank(1);  o.ir_we  = 1'b1; exp_seq.push_back(o);
    exp_seq.push_back(blank(2));
    case (k)
      K_ALU: begin
        o = blank(3); o.flags_we = 1'b1; o.rf_we = (ins[7:4] != 4'hB); exp_seq.push_back(o);
      end
      K_ALUI: begin
        o = blank(4); o.flags_we = 1'b1; o.alu_op = 1'b1; o.muxb = 2'd1;
        o.rf_we = (ins[15:12] != 4'hB); exp_seq.push_back(o);
      end
      K_MOV:   begin o = blank(5); o.rf_we = 1'b1; o.muxrf = 2'd2; exp_seq.push_back(o); end
      K_MOVI:  begin o = blank(6); o.rf_we = 1'b1; o.muxrf = 2'd3; exp_seq.push_back(o); end
      K_LOAD: begin
        exp_seq.push_back(blank(7));
        o = blank(8); o.rf_we = 1'b1; o.muxrf = 2'd1; exp_seq.push_back(o);
      end
      K_STORE: begin o = blank(9); o.mem_we = 1'b1; exp_seq.push_back(o); end
      K_BRANCH: begin
        taken = cond_holds(ins[11:8], fl);
        o = blank(10); o.muxa = 1'b1; o.muxb = 2'd1; o.force_add = 1'b1; o.pc_we = taken;
        exp_seq.push_back(o);
      end
      K_JUMP: begin
        taken = cond_holds(ins[11:8], fl);
        o = blank(11); o.muxpc = 1'b1; o.pc_we = taken; exp_seq.push_back(o);
      end
      default: ;
    endcase
    if (!taken) begin
      o = blank(12); o.muxa = 1'b1; o.muxb = 2'd2; o.force_add = 1'b1; o.pc_we = 1'b1;
      exp_seq.push_back(o);
    end
  endfunction

  // Called just after a clock edge; issues the first k cycles of an instruction (k<0: all)
  task automatic issue(input logic [15:0] ins, input logic [4:0] fl, input int k);
    int n;
    build(ins, fl);
    n = (k < 0 || k > exp_seq.size()) ? exp_seq.size() : k;
    instr = ins;
    flags = fl;
    for (int i = 0; i < n; i++) sb_q.push_back(exp_seq[i]);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) sb_q.push_back(blank(0));
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: one observation per cycle, compared against the head of the scoreboard
  initial begin
    obs_t got, expv;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      got = {state, ir_we, pc_we, rf_we, mem_we, flags_we, muxrf_select, muxpc_select,
             muxmem_select, muxa_select, muxb_select, alu_op_select, alu_force_add};
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL underflow t=%0t got=%h required=<nothing queued>", $time, got);
      end else begin
        expv = sb_q.pop_front();
        if (got !== expv) begin
          n_bad++;
          $display("FAIL trace t=%0t instr=%h flags=%b got=%h required=%h",
                   $time, instr, flags, got, expv);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    logic [4:0]  fl;
    logic [3:0]  pick[7];
    int          k;
    pick  = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
    reset = 1'b1;
    instr = 16'h0;
    flags = 5'h0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Reset landing on the load write-back cycle must suppress rf_we
    issue(16'h4302, 5'h1F, 4);
    do_reset(2);

    issue(16'h0552, 5'h00, -1);   // ADD R5,R2 (ext=ADD)
    issue(16'h05B2, 5'h1F, -1);   // CMP: flags only
    issue(16'h0512, 5'h00, -1);   // ext=AND
    issue(16'h0B12, 5'h00, -1);
    issue(16'h4302, 5'h00, -1);   // LOAD R3,[R2]
    issue(16'h4342, 5'h00, -1);   // STORE
    issue(16'hC0FE, 5'h02, -1);   // BEQ taken
    issue(16'hC0FE, 5'h00, -1);   // BEQ not taken
    issue(16'h4EC7, 5'h00, -1);   // JUC
    issue(16'h4FC7, 5'h1F, -1);   // never
    issue(16'h7000, 5'h00, -1);   // undefined -> NOP
    issue(16'hB312, 5'h00, -1);   // CMPI
    issue(16'h5312, 5'h00, -1);   // ADDI
    issue(16'h03D4, 5'h00, -1);   // MOV
    issue(16'hD3AA, 5'h00, -1);   // MOVI
    issue(16'hF3AA, 5'h00, -1);   // LUI

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: ins = {4'h0, 4'($urandom_range(0, 15)), pick[$urandom_range(0, 6)], 4'($urandom_range(0, 15))};
        1: ins = {4'h4, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & 4'hC, 4'($urandom_range(0, 15))};
        2: ins = {4'hC, 16'($urandom) & 12'hFFF};
        3: ins = {4'h4, 4'($urandom_range(0, 15)), 4'hC, 4'($urandom_range(0, 15))};
        default: ins = 16'($urandom);
      endcase
      fl = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) begin
        build(ins, fl);
        k = $urandom_range(1, exp_seq.size() - 1);
        issue(ins, fl, k);
        do_reset($urandom_range(1, 2));
      end else begin
        issue(ins, fl, -1);
      end
    end

    done = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d unconsumed expectations, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
